// File: rtl/float_pkg.sv
// Shared definitions for the sequential floating-point divider.
//   state_t       : controller states
//   class_t       : operand-pair classification decided before division
//   exp_bias()    : exponent bias for an E-bit exponent field
//   unpack_fields(): splits a float word (up to 64 bits) into sign/exponent/mantissa
//   special_word(): builds canonical NaN or signed infinity/zero for any E/M
//   SP_*          : the same special encodings for the default 32-bit format
package float_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ITER,
        ST_PACK,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } class_t;

    localparam logic [31:0] SP_NAN  = 32'h7FC0_0000;
    localparam logic [31:0] SP_INF  = 32'h7F80_0000;
    localparam logic [31:0] SP_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic        sign;
        logic [15:0] exp;
        logic [63:0] mant;
    } fields_t;

    function automatic int exp_bias(input int e_w);
        return (1 << (e_w - 1)) - 1;
    endfunction

    function automatic fields_t unpack_fields(input logic [63:0] word, input int e_w, input int m_w);
        fields_t     f;
        logic [63:0] sh;
        sh     = word >> m_w;
        f.sign = word[e_w + m_w];
        f.exp  = sh[15:0] & ((16'd1 << e_w) - 16'd1);
        f.mant = word & ((64'd1 << m_w) - 64'd1);
        return f;
    endfunction

    function automatic logic [63:0] special_word(input class_t cls, input logic sign,
                                                 input int e_w, input int m_w);
        logic [63:0] exp_ones;
        logic [63:0] sign_bit;
        exp_ones = ((64'd1 << e_w) - 64'd1) << m_w;
        sign_bit = {63'd0, sign} << (e_w + m_w);
        case (cls)
            CLS_NAN: return exp_ones | (64'd1 << (m_w - 1));
            CLS_INF: return sign_bit | exp_ones;
            default: return sign_bit;
        endcase
    endfunction

endpackage

// File: rtl/float_seq_divider_mant_div_iter.sv
// Radix-2 restoring mantissa divider, one quotient bit per clock, MSB first.
// Ports:
//   clk, reset          : clock, async active-high reset
//   start               : load dividend/divisor and begin M+2 steps
//   dividend, divisor   : {1,mantissa} operands, M+1 bits each
//   last                : high during the final step cycle (quotient complete after that edge)
//   quotient            : M+2-bit quotient, bit M+1 has weight 1
module mant_div_iter
    import float_pkg::*;
#(
    parameter int M = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [M:0]   dividend,
    input  logic [M:0]   divisor,
    output logic         last,
    output logic [M+1:0] quotient
);

    localparam int CW = $clog2(M + 2);
    // Counting M+1 down to 0 gives M+2 steps and always fits in CW bits.
    localparam logic [CW-1:0] CNT_LOAD = CW'(M + 1);

    logic [M+1:0]  rem_q, rem_d;
    logic [M:0]    div_q, div_d;
    logic [M+1:0]  quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;

    logic [M+2:0]  diff;
    logic          ge;
    logic [M+1:0]  rem_sel;
    logic          unused_rem;

    // Remainder stays below 2*divisor, so after subtracting it fits in M+1 bits.
    assign diff       = {1'b0, rem_q} - {2'b00, div_q};
    assign ge         = ~diff[M+2];
    assign rem_sel    = ge ? diff[M+1:0] : rem_q;
    assign unused_rem = rem_sel[M+1];

    always_comb begin
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            rem_d    = {1'b0, dividend};
            div_d    = divisor;
            quo_d    = '0;
            cnt_d    = CNT_LOAD;
            active_d = 1'b1;
        end else if (active_q) begin
            rem_d = {rem_sel[M:0], 1'b0};
            quo_d = {quo_q[M:0], ge};
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign last     = active_q && (cnt_q == '0);
    assign quotient = quo_q;

endmodule

// File: rtl/float_seq_divider.sv
// Sequential floating-point divider, out = in1 / in2, fixed latency of M+4
// cycles from accept to out_valid. Denormal inputs are treated as zero and
// results are truncated toward zero.
// Ports:
//   clk, reset           : clock, async active-high reset
//   in_valid / in_ready  : operand handshake (ready only when idle)
//   in1, in2             : dividend, divisor
//   out_valid / out_ready: result handshake, out held while valid
//   out                  : quotient
//   busy                 : high whenever not idle
//
// state    | meaning
// IDLE     | waiting for operands
// SETUP    | unpack, sign/exponent, classify specials, start mantissa divider
// ITER     | M+2 restoring-division steps
// PACK     | normalise, range-check exponent, select special result
// DONE     | result offered until out_ready
module float_seq_divider
    import float_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  busy
);

    localparam int XW = E + 2;
    localparam logic signed [XW-1:0] BIAS_X    = XW'(exp_bias(E));
    localparam logic signed [XW-1:0] EXP_MAX_X = XW'((1 << E) - 1);
    localparam logic signed [XW-1:0] ONE_X     = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X    = XW'(0);
    localparam logic [E-1:0]         EXP_ONES  = '1;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  op1_q, op1_d;
    logic [DATA_WIDTH-1:0]  op2_q, op2_d;
    logic                   sign_q, sign_d;
    logic signed [XW-1:0]   exp_q, exp_d;
    class_t                 cls_q, cls_d;
    logic [DATA_WIDTH-1:0]  out_q, out_d;

    fields_t                f1, f2;
    logic [E-1:0]           e1, e2;
    logic [M-1:0]           m1, m2;
    logic                   z1, z2, inf1, inf2, nan1, nan2;
    logic signed [XW-1:0]   exp_calc;
    class_t                 cls_calc;

    logic                   iter_start;
    logic                   iter_last;
    logic [M+1:0]           quo;

    logic signed [XW-1:0]   exp_norm;
    logic [M-1:0]           mant_norm;
    class_t                 res_cls;
    logic [63:0]            spec_word;
    logic                   unused_fields;

    assign f1 = unpack_fields(64'(op1_q), E, M);
    assign f2 = unpack_fields(64'(op2_q), E, M);
    assign e1 = f1.exp[E-1:0];
    assign e2 = f2.exp[E-1:0];
    assign m1 = f1.mant[M-1:0];
    assign m2 = f2.mant[M-1:0];
    assign unused_fields = ^{f1, f2, spec_word};

    // Exponent field 0 covers both zero and denormals; both count as zero.
    assign z1   = (e1 == '0);
    assign z2   = (e2 == '0);
    assign inf1 = (e1 == EXP_ONES) && (m1 == '0);
    assign inf2 = (e2 == EXP_ONES) && (m2 == '0);
    assign nan1 = (e1 == EXP_ONES) && (m1 != '0);
    assign nan2 = (e2 == EXP_ONES) && (m2 != '0);

    assign exp_calc = signed'({2'b00, e1}) - signed'({2'b00, e2}) + BIAS_X;

    always_comb begin
        cls_calc = CLS_NORM;
        if (nan1 || nan2 || (z1 && z2) || (inf1 && inf2)) begin
            cls_calc = CLS_NAN;
        end else if (inf1 || z2) begin
            cls_calc = CLS_INF;
        end else if (z1 || inf2) begin
            cls_calc = CLS_ZERO;
        end
    end

    assign iter_start = (state_q == ST_SETUP);

    mant_div_iter #(.M(M)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .start    (iter_start),
        .dividend ({1'b1, m1}),
        .divisor  ({1'b1, m2}),
        .last     (iter_last),
        .quotient (quo)
    );

    // Quotient lies in (0.5, 2): a clear MSB means one left shift is needed.
    always_comb begin
        if (quo[M+1]) begin
            exp_norm  = exp_q;
            mant_norm = quo[M:1];
        end else begin
            exp_norm  = exp_q - ONE_X;
            mant_norm = quo[M-1:0];
        end
        res_cls = cls_q;
        if (cls_q == CLS_NORM) begin
            if (exp_norm >= EXP_MAX_X) begin
                res_cls = CLS_INF;
            end else if (exp_norm <= ZERO_X) begin
                res_cls = CLS_ZERO;
            end
        end
    end

    assign spec_word = special_word(res_cls, sign_q, E, M);

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        cls_d   = cls_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op1_d   = in1;
                    op2_d   = in2;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                sign_d  = f1.sign ^ f2.sign;
                exp_d   = exp_calc;
                cls_d   = cls_calc;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                if (iter_last) begin
                    state_d = ST_PACK;
                end
            end
            ST_PACK: begin
                if (res_cls == CLS_NORM) begin
                    out_d = {sign_q, exp_norm[E-1:0], mant_norm};
                end else begin
                    out_d = spec_word[DATA_WIDTH-1:0];
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            cls_q   <= CLS_NORM;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            cls_q   <= cls_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;

endmodule

// File: tb/tb_float_seq_divider.sv
module tb_float_seq_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    float_seq_divider #(.DATA_WIDTH(32), .E(8), .M(23)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle and out_ready high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input string tag);
        int cycles;
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 60) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, " latency"}, 32'(cycles), 32'd27);
        check({tag, " out"}, out, expv);
        @(posedge clk);
        #1;
        check({tag, " released"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int cycles;
        int seen;

        // Reset state
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst out", out, 32'h0);
        check("rst flags", {29'd0, out_valid, busy, in_ready}, 32'b001);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post-rst ready", {31'd0, in_ready}, 32'd1);

        // Normal quotients
        run_op(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, "6/3");
        run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, "1/3");
        run_op(32'h40A0_0000, 32'h4080_0000, 32'h3FA0_0000, "5/4");
        run_op(32'hC0C0_0000, 32'h4040_0000, 32'hC000_0000, "-6/3");

        // Special cases
        run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, "1/0");
        run_op(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, "-1/0");
        run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, "0/0");
        run_op(32'h0000_0000, 32'h4000_0000, 32'h0000_0000, "0/2");
        run_op(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, "inf/inf");
        run_op(32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, "2/inf");
        run_op(32'h0040_0000, 32'h4000_0000, 32'h0000_0000, "denorm/2");

        // Overflow / underflow
        run_op(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, "overflow");
        run_op(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, "underflow");

        // Backpressure with an ignored in_valid pulse during ITER
        out_ready = 1'b0;
        in1 = 32'h40A0_0000;
        in2 = 32'h4080_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 60) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 5) begin
                check("bp busy ready", {30'd0, busy, in_ready}, 32'b10);
                in1 = 32'h3F80_0000;
                in2 = 32'h4040_0000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("bp latency", 32'(cycles), 32'd27);
        check("bp out", out, 32'h3FA0_0000);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp hold flags", {30'd0, out_valid, in_ready}, 32'b10);
            check("bp hold out", out, 32'h3FA0_0000);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp released", {30'd0, out_valid, in_ready}, 32'b01);

        // Reset during ITER cycle 10
        in1 = 32'h40C0_0000;
        in2 = 32'h4040_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid rst flags", {29'd0, out_valid, busy, in_ready}, 32'b001);
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("mid no output", 32'(seen), 32'd0);
        run_op(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, "6/3 after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_seq_divider.md
FLOAT_SEQ_DIVIDER -- requirements
Module: float_seq_divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, total float width.
REQ-002 SHALL have parameter E, default 8, exponent width.
REQ-003 SHALL have parameter M, default 23, stored mantissa width; DATA_WIDTH = 1+E+M.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand pair present.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have port in1  input  DATA_WIDTH  dividend.
REQ-009 SHALL have port in2  input  DATA_WIDTH  divisor; any value, no lookup table.
REQ-010 SHALL have port out_valid  output  1  quotient present.
REQ-011 SHALL have port out_ready  input  1  consumer takes quotient.
REQ-012 SHALL have port out  output  DATA_WIDTH  quotient in1/in2.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL accept an operation on a rising edge with in_valid and in_ready both high, capturing in1/in2.
REQ-015 SHALL assert in_ready only in IDLE; one operation in flight, no input buffering.
REQ-016 SHALL run FSM IDLE -> SETUP (1 cycle) -> ITER (M+2 cycles) -> PACK (1 cycle) -> DONE -> IDLE.
REQ-017 SETUP SHALL: unpack fields, sign = s1 XOR s2, exponent = e1 - e2 + bias computed at E+2 bits signed, classify special cases.
REQ-018 ITER SHALL perform radix-2 restoring division of {1,m1} by {1,m2}, one quotient bit per cycle, MSB first, M+2 bits total, using an iteration counter of clog2(M+2) bits.
REQ-019 PACK SHALL normalise: if the quotient MSB is 0, shift left by 1 and decrement the exponent; truncate the remaining bits (round toward zero).
REQ-020 SHALL hold out_valid high in DONE until out_ready is high; transfer on the edge where both are high, then return to IDLE.
REQ-021 Latency from the accept edge to out_valid high SHALL be exactly M+4 cycles (27 at defaults), including special cases.
REQ-022 out SHALL be stable while out_valid is high.
REQ-023 Denormal inputs (exponent 0) SHALL be treated as signed zero; no denormal outputs are produced.
REQ-024 x/0 with x nonzero and finite SHALL give signed infinity; 0/0, inf/inf, and any NaN input SHALL give canonical NaN 0x7FC00000 (sign 0, exponent all ones, mantissa MSB set).
REQ-025 0/x with x nonzero SHALL give signed zero; finite/inf SHALL give signed zero; inf/finite SHALL give signed infinity.
REQ-026 A biased result exponent >= 2^E-1 SHALL give signed infinity; <= 0 SHALL give signed zero.
REQ-027 in_valid while not in IDLE SHALL be ignored, and held operands SHALL not be corrupted.

Reset
REQ-028 Reset SHALL force IDLE asynchronously, with in_ready=1 after release, out_valid=0, busy=0, out=0, and counter and datapath registers = 0.
REQ-029 Reset mid-operation SHALL abort the operation with no output produced; the next accept SHALL behave as after power-up.

Structure
REQ-030 Shared package float_pkg SHALL hold FSM state enum, bias function of E, canonical NaN/inf/zero constants, and a field-unpack helper.
REQ-031 One sub-module mant_div_iter SHALL implement the restoring-division step (remainder and quotient registers, start/done); the top holds the FSM, special-case logic and packing.

Verification
REQ-032 6.0/3.0: in1=0x40C00000, in2=0x40400000 -> out=0x40000000, out_valid exactly 27 cycles after accept.
REQ-033 1.0/3.0: 0x3F800000 / 0x40400000 -> 0x3EAAAAAA (truncated); 5.0/4.0 -> 0x3FA00000.
REQ-034 Specials: 1.0/0.0 -> 0x7F800000; -1.0/0.0 -> 0xFF800000; 0/0 -> 0x7FC00000; 0x00000000/2.0 -> 0x00000000; each at 27-cycle latency.
REQ-035 Backpressure: out_ready held low for 10 cycles -> out_valid and out stable, in_ready low, then transfer completes; in_valid pulsed during ITER is ignored.
REQ-036 Overflow/underflow: 0x7F000000/0x3E800000 -> 0x7F800000; 0x00800000/0x40000000 -> 0x00000000.
REQ-037 Reset asserted at ITER cycle 10 -> immediate IDLE, no out_valid; a following 6.0/3.0 gives the correct result.
